// File: rtl/dlbf_pkg.sv
// Shared types and defaults for the stream capture block.
package dlbf_pkg;

  localparam int DLBF_RAM_DEPTH  = 4096;
  localparam int DLBF_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  // A block size is usable when it is non-zero and fits in the RAM.
  function automatic logic size_legal(input logic [15:0] size, input int depth);
    return (size != 16'd0) && (int'(size) <= depth);
  endfunction

endpackage

// File: rtl/dlbf_sat_cnt.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module dlbf_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dlbf_cout_capture.sv
// Captures a fixed-length AXI-stream block into an external RAM write port.
//   state      | meaning
//   ST_IDLE    | waiting for a start since reset
//   ST_CAPTURE | accepting beats, tready high
//   ST_DONE    | block complete, beat_cnt holds the final count
module dlbf_cout_capture
  import dlbf_pkg::*;
#(
  parameter int RAM_DEPTH  = DLBF_RAM_DEPTH,
  parameter int DATA_WIDTH = DLBF_DATA_WIDTH
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    start,
  input  logic [15:0]             block_size,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [15:0]             beat_cnt,
  output logic [7:0]              tlast_err_cnt,
  output logic [15:0]             addrb,
  output logic [DATA_WIDTH-1:0]   dinb,
  output logic                    enb,
  output logic [DATA_WIDTH/8-1:0] web
);

  localparam int BYTES = DATA_WIDTH / 8;

  cap_state_e  state_q, state_n;
  logic [15:0] size_q;
  logic [15:0] wr_ptr_q;
  logic        accept;
  logic        last_beat;
  logic        size_ok;
  logic        start_ok;
  logic        start_bad;
  logic        tlast_err;
  logic        tready_n;
  logic        busy_n;
  logic        done_n;

  assign size_ok   = size_legal(block_size, RAM_DEPTH);
  assign start_ok  = start && (state_q != ST_CAPTURE) && size_ok;
  assign start_bad = start && (state_q != ST_CAPTURE) && !size_ok;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign last_beat = accept && (beat_cnt == (size_q - 16'd1));
  assign tlast_err = accept && (last_beat ? !s_axis_tlast : s_axis_tlast);

  always_comb begin
    state_n  = state_q;
    tready_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tready_n = 1'b1;
        busy_n   = 1'b1;
        if (last_beat) state_n = ST_DONE;
      end
      ST_DONE: begin
        done_n = 1'b1;
        if (start_ok) state_n = ST_CAPTURE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign s_axis_tready = tready_n;
  assign busy          = busy_n;
  assign done          = done_n;

  always_ff @(posedge s_axis_clk) begin
    if (s_axis_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // The pointer stops on the final beat so it never leaves 0..RAM_DEPTH-1;
  // the next start reloads it anyway.
  always_ff @(posedge s_axis_clk) begin
    if (s_axis_rst) begin
      size_q   <= 16'd0;
      wr_ptr_q <= 16'd0;
      cfg_err  <= 1'b0;
    end else begin
      if (start_ok) begin
        size_q   <= block_size;
        wr_ptr_q <= 16'd0;
        cfg_err  <= 1'b0;
      end else if (start_bad) begin
        cfg_err  <= 1'b1;
      end
      if (accept && !last_beat) begin
        wr_ptr_q <= wr_ptr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge s_axis_clk) begin
    if (s_axis_rst) begin
      enb   <= 1'b0;
      web   <= '0;
      addrb <= 16'd0;
      dinb  <= '0;
    end else begin
      enb <= accept;
      web <= {BYTES{accept}};
      if (accept) begin
        addrb <= wr_ptr_q;
        dinb  <= s_axis_tdata;
      end
    end
  end

  dlbf_sat_cnt #(.WIDTH(16)) u_beat_cnt (
    .clk (s_axis_clk),
    .rst (s_axis_rst),
    .clr (start_ok),
    .inc (accept),
    .cnt (beat_cnt)
  );

  dlbf_sat_cnt #(.WIDTH(8)) u_tlast_err_cnt (
    .clk (s_axis_clk),
    .rst (s_axis_rst),
    .clr (1'b0),
    .inc (tlast_err),
    .cnt (tlast_err_cnt)
  );

endmodule
